// File: rtl/mips_pkg.sv
// Shared pipeline-control definitions: controller states, the register-number
// width, the default memory-wait limit and the load-use hazard test.
package mips_pkg;

  localparam int unsigned REG_W                = 5;
  localparam int unsigned WAIT_W               = 8;
  localparam int unsigned CNT_W                = 16;
  localparam int unsigned MEM_WAIT_MAX_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_t;

  // Register 0 is hard-wired, so a load into it never creates a dependency.
  function automatic logic load_use(input logic             mem_read,
                                    input logic [REG_W-1:0] exe_rt,
                                    input logic [REG_W-1:0] id_rs,
                                    input logic [REG_W-1:0] id_rt);
    return mem_read && (exe_rt != '0) && ((exe_rt == id_rs) || (exe_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counters: stall cycles (pc_en low) and taken-branch cycles.
module pipe_ctrl_perf
  import mips_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pc_en,
  input  logic             branch_taken,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/freeze controller (RUN / MEM_WAIT / HALT).
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] exe_rt,
  input  logic             exe_mem_read,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idexe_en,
  output logic             idexe_flush,
  output logic             exemem_en,
  output logic             exemem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  ctrl_state_t       state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze, halt_now;
  logic              taken, hazard;

  assign taken  = mem_branch && mem_zero;
  assign hazard = load_use(exe_mem_read, exe_rt, id_rs, id_rt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if ((state == ST_RUN) && (next_state == ST_MEM_WAIT))
        wait_cnt <= '0;
      else if ((state == ST_MEM_WAIT) && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state    = state;
    freeze        = 1'b0;
    halt_now      = 1'b0;
    pc_en         = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idexe_en      = 1'b1;
    idexe_flush   = 1'b0;
    exemem_en     = 1'b1;
    exemem_flush  = 1'b0;
    memwb_flush   = 1'b0;
    halted        = 1'b0;

    case (state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          freeze     = 1'b1;
          next_state = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        // A released freeze falls through to the RUN decode below, so a branch
        // held in EXE/MEM during the wait is acted on in this cycle.
        if (!mem_ready) begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_LAST)
            next_state = ST_HALT;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_HALT:  halt_now   = 1'b1;
      default:  next_state = ST_RUN;
    endcase

    if (halt_now) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idexe_en     = 1'b0;
      exemem_en    = 1'b0;
      ifid_flush   = 1'b1;
      idexe_flush  = 1'b1;
      exemem_flush = 1'b1;
      memwb_flush  = 1'b1;
      halted       = 1'b1;
    end else if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idexe_en    = 1'b0;
      exemem_en   = 1'b0;
      memwb_flush = 1'b1;
    end else if (taken) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      idexe_flush   = 1'b1;
      exemem_flush  = 1'b1;
    end else if (hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idexe_flush = 1'b1;
    end

    // Reset drives the safe pattern combinationally, ahead of any clock edge.
    if (!reset_n) begin
      pc_en         = 1'b0;
      pc_sel_branch = 1'b0;
      ifid_en       = 1'b0;
      ifid_flush    = 1'b1;
      idexe_en      = 1'b0;
      idexe_flush   = 1'b1;
      exemem_en     = 1'b0;
      exemem_flush  = 1'b1;
      memwb_flush   = 1'b1;
      halted        = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clock        (clock),
    .reset_n      (reset_n),
    .pc_en        (pc_en),
    .branch_taken (pc_sel_branch),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with MEM_WAIT_MAX=4; counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  id_rs, id_rt, exe_rt;
  logic        exe_mem_read, mem_branch, mem_zero, mem_req, mem_ready;
  logic        pc_en, pc_sel_branch, ifid_en, ifid_flush, idexe_en, idexe_flush;
  logic        exemem_en, exemem_flush, memwb_flush, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [9:0]  ctl;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // {pc_en,pc_sel,ifid_en,ifid_fl,idexe_en,idexe_fl,exemem_en,exemem_fl,memwb_fl,halted}
  localparam logic [9:0] C_RUN  = 10'b1_0_1_0_1_0_1_0_0_0;
  localparam logic [9:0] C_RST  = 10'b0_0_0_1_0_1_0_1_1_0;
  localparam logic [9:0] C_HAZ  = 10'b0_0_0_0_1_1_1_0_0_0;
  localparam logic [9:0] C_BR   = 10'b1_1_1_1_1_1_1_1_0_0;
  localparam logic [9:0] C_FRZ  = 10'b0_0_0_0_0_0_0_0_1_0;
  localparam logic [9:0] C_HALT = 10'b0_0_0_1_0_1_0_1_1_1;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [15:0] EXP_STALL3 = 16'd3;
`else
  localparam logic [15:0] EXP_STALL3 = 16'd0;
`endif

  assign ctl = {pc_en, pc_sel_branch, ifid_en, ifid_flush, idexe_en, idexe_flush,
                exemem_en, exemem_flush, memwb_flush, halted};

  always #5 clock = ~clock;

  pipe_ctrl #(.MEM_WAIT_MAX(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .exe_rt(exe_rt), .exe_mem_read(exe_mem_read),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idexe_en(idexe_en), .idexe_flush(idexe_flush),
    .exemem_en(exemem_en), .exemem_flush(exemem_flush), .memwb_flush(memwb_flush),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [9:0] exp);
    @(negedge clock);
    chk(tag, {6'd0, ctl}, {6'd0, exp});
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; exe_rt = 5'd0; exe_mem_read = 1'b0;
    mem_branch = 1'b0; mem_zero = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    @(negedge clock);
    chk("reset_ctl", {6'd0, ctl}, {6'd0, C_RST});
    chk("reset_stall_cnt", stall_cnt, 16'd0);
    chk("reset_flush_cnt", flush_cnt, 16'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    step("run_idle", C_RUN);

    // Load-use hazards
    exe_mem_read = 1'b1; exe_rt = 5'd8; id_rs = 5'd8;
    step("haz_rs", C_HAZ);
    idle();
    step("haz_release", C_RUN);
    exe_mem_read = 1'b1; exe_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9;
    step("haz_rt", C_HAZ);
    idle(); exe_mem_read = 1'b1;
    step("haz_r0", C_RUN);
    exe_rt = 5'd8; id_rs = 5'd5; id_rt = 5'd6;
    step("haz_nomatch", C_RUN);
    exe_mem_read = 1'b0; id_rs = 5'd8;
    step("haz_noload", C_RUN);

    // Taken branch beats load-use; untaken branch does nothing
    exe_mem_read = 1'b1; exe_rt = 5'd8; id_rs = 5'd8; mem_branch = 1'b1; mem_zero = 1'b1;
    step("br_over_haz", C_BR);
    idle(); mem_branch = 1'b1;
    step("br_not_taken", C_RUN);
    idle();

    // Fresh counters for the memory-wait scenario
    reset_n = 1'b0;
    step("reset_pulse", C_RST);
    reset_n = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0;
    step("mw_c1", C_FRZ);
    step("mw_c2", C_FRZ);
    step("mw_c3", C_FRZ);
    mem_ready = 1'b1;
    step("mw_release", C_RUN);
    idle();
    step("mw_after", C_RUN);
    chk("mw_stall_cnt", stall_cnt, EXP_STALL3);
    chk("mw_flush_cnt", flush_cnt, 16'd0);

    // Branch arriving during the wait is acted on at release
    mem_req = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
    step("mwbr_c1", C_FRZ);
    step("mwbr_c2", C_FRZ);
    mem_ready = 1'b1;
    step("mwbr_release", C_BR);
    idle();
    step("mwbr_after", C_RUN);

    // Timeout: MEM_WAIT_MAX=4 -> five frozen cycles, then HALT
    mem_req = 1'b1; mem_ready = 1'b0;
    step("to_c1", C_FRZ);
    step("to_c2", C_FRZ);
    step("to_c3", C_FRZ);
    step("to_c4", C_FRZ);
    step("to_c5", C_FRZ);
    step("to_halt", C_HALT);
    idle(); mem_ready = 1'b1;
    step("to_halt_sticky", C_HALT);
    reset_n = 1'b0;
    step("halt_reset", C_RST);
    reset_n = 1'b1;
    step("halt_exit", C_RUN);

    // Asynchronous reset in the middle of a wait
    mem_req = 1'b1; mem_ready = 1'b0;
    step("ar_enter", C_FRZ);
    @(negedge clock);
    chk("ar_frozen", {6'd0, ctl}, {6'd0, C_FRZ});
    #1 reset_n = 1'b0;
    #1 chk("ar_async", {6'd0, ctl}, {6'd0, C_RST});
    @(posedge clock); #1;
    idle();
    reset_n = 1'b1;
    step("ar_exit", C_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one parameter: MEM_WAIT_MAX, 15, maximum consecutive data-memory wait cycles before halting (range 1..255).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  pipeline clock, rising edge active.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 exe_rt  input  5  destination register of the instruction in EXE.
REQ-007 exe_mem_read  input  1  instruction in EXE is a load.
REQ-008 mem_branch, mem_zero  input  1 each  branch control bit and zero flag held in the EXE/MEM register.
REQ-009 mem_req, mem_ready  input  1 each  data-memory access active in MEM; data memory completes this cycle.
REQ-010 pc_en, pc_sel_branch  output  1 each  PC load enable; select branch target.
REQ-011 ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en, exemem_flush, memwb_flush  output  1 each  pipeline-register enables and flushes (flush = load zeroed control fields).
REQ-012 halted  output  1  memory-timeout halt indication.
REQ-013 stall_cnt, flush_cnt  output  16 each  performance counters.

Function
REQ-014 FSM states SHALL be RUN, MEM_WAIT and HALT; outputs SHALL be combinational from state and inputs.
REQ-015 Defaults in RUN SHALL be: all enables 1, all flushes 0, pc_sel_branch 0.
REQ-016 Priority in RUN SHALL be memory wait > taken branch > load-use hazard.
REQ-017 Memory wait (mem_req=1, mem_ready=0) in RUN SHALL clear pc_en, ifid_en, idexe_en and exemem_en, set memwb_flush, and move to MEM_WAIT next cycle.
REQ-018 In MEM_WAIT with mem_ready=0, the freeze outputs of REQ-017 SHALL hold and the wait counter SHALL increment.
REQ-019 In MEM_WAIT with mem_ready=1, outputs SHALL be those RUN would produce for the current inputs, ignoring mem_req, and the next state SHALL be RUN.
REQ-020 When the wait counter reaches MEM_WAIT_MAX with mem_ready=0, the next state SHALL be HALT.
REQ-021 HALT SHALL clear all enables, set all flushes and set halted=1, and SHALL be left only by reset.
REQ-022 Taken branch (mem_branch & mem_zero) SHALL set pc_sel_branch and assert ifid_flush, idexe_flush and exemem_flush for exactly one cycle.
REQ-023 Load-use hazard (exe_mem_read & exe_rt!=0 & (exe_rt==id_rs | exe_rt==id_rt)) SHALL clear pc_en and ifid_en and set idexe_flush for one cycle.
REQ-024 exe_rt=0 SHALL never raise a hazard.
REQ-025 The wait counter SHALL be 8 bits and clear on every entry to MEM_WAIT.
REQ-026 A branch arriving during MEM_WAIT SHALL be evaluated when the freeze releases.

Reset
REQ-027 While reset_n=0, all enables SHALL be 0, all flushes 1, pc_sel_branch 0, halted 0 and counters 0.
REQ-028 After release, state SHALL be RUN and the wait counter 0.
REQ-029 Reset asserted in MEM_WAIT or HALT SHALL abort it immediately.

Configuration
REQ-030 With PIPE_CTRL_PERF_EN defined, stall_cnt SHALL count cycles with pc_en=0 and flush_cnt SHALL count taken-branch cycles; both SHALL saturate at 16'hFFFF.
REQ-031 Without PIPE_CTRL_PERF_EN, stall_cnt and flush_cnt SHALL be tied to 0 and no counter flops SHALL be built.

Structure
REQ-032 The state encoding, the 5-bit register-number width and the default for MEM_WAIT_MAX SHALL live in the shared package mips_pkg.
REQ-033 The performance counters SHALL be one sub-module, pipe_ctrl_perf, instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-034 Scenario: exe_mem_read=1, exe_rt=8, id_rs=8 -> for one cycle pc_en=0, ifid_en=0, idexe_flush=1.
REQ-035 Scenario: exe_mem_read=1, exe_rt=0, id_rs=0 -> no stall; all enables 1.
REQ-036 Scenario: mem_branch=1, mem_zero=1 together with a load-use hazard -> pc_sel_branch=1 and three flushes asserted; pc_en=1.
REQ-037 Scenario: mem_req=1, mem_ready low for 3 cycles, then high -> 3 frozen cycles with memwb_flush=1, RUN on the 4th cycle; stall_cnt=3 when PIPE_CTRL_PERF_EN is defined.
REQ-038 Scenario: MEM_WAIT_MAX=4, mem_ready held 0 -> halted=1 after 5 cycles and stays 1; reset_n pulse returns RUN with halted=0.
REQ-039 Scenario: reset_n dropped mid-MEM_WAIT -> outputs take reset values asynchronously, before the next clock edge.
